// File: rtl/nete_rx_unpack.sv
// nete_rx_unpack: drains the NETE RX packet FIFO (256-bit words) and the byte-count
// FIFO (one 64-bit entry per packet). Each packet is re-serialised onto a 64-bit
// AXI-Stream with LSB-aligned tkeep and tlast.
//
// Build option: define NETE_RX_UNPACK_STATS_EN to build the packet/byte counters.
// Without it, pkt_count and byte_count are tied to 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   fifo_pkt_*          packet FIFO read side (q valid one cycle after rden)
//   fifo_bcnt_*         byte-count FIFO read side (count in q[15:0])
//   m_axis_*            64-bit AXI-Stream master toward the OmniXtend RX datapath
//   err_zero_len        one-cycle pulse when a zero byte count is consumed
//   err_oversize        one-cycle pulse when a byte count exceeds MAX_PKT_BYTES
//   busy                high whenever the FSM is not idle
//   pkt_count           packets emitted (stats build only)
//   byte_count          bytes emitted (stats build only)
module nete_rx_unpack #(
   parameter int unsigned MAX_PKT_BYTES = 2048,
   parameter logic [3:0]  TDEST_VAL     = 4'd0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [255:0] fifo_pkt_q,
   input  logic         fifo_pkt_empty,
   output logic         fifo_pkt_rden,
   input  logic [63:0]  fifo_bcnt_q,
   input  logic         fifo_bcnt_empty,
   output logic         fifo_bcnt_rden,
   output logic [63:0]  m_axis_tdata,
   output logic [7:0]   m_axis_tkeep,
   output logic         m_axis_tvalid,
   output logic         m_axis_tlast,
   output logic [3:0]   m_axis_tdest,
   input  logic         m_axis_tready,
   output logic         err_zero_len,
   output logic         err_oversize,
   output logic         busy,
   output logic [31:0]  pkt_count,
   output logic [31:0]  byte_count
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] BCNT_RD  = 3'd1;
   localparam logic [2:0] BCNT_LAT = 3'd2;
   localparam logic [2:0] PKT_RD   = 3'd3;
   localparam logic [2:0] PKT_LAT  = 3'd4;
   localparam logic [2:0] SEND     = 3'd5;
   localparam logic [2:0] DONE     = 3'd6;

   logic [2:0]   state_q, state_d;
   logic [15:0]  rem_q, rem_d;
   logic [1:0]   lane_q, lane_d;
   logic [255:0] word_q, word_d;

   logic [15:0]  bcnt;
   logic [15:0]  beat_bytes;
   logic         sending;
   logic         beat_last;
   logic         beat_accept;

   // Only the 16-bit count is meaningful; the rest of the entry is ignored.
   logic unused_bcnt_hi;
   assign unused_bcnt_hi = ^fifo_bcnt_q[63:16];

   assign bcnt        = fifo_bcnt_q[15:0];
   assign sending     = (state_q == SEND);
   assign beat_last   = (rem_q <= 16'd8);
   assign beat_bytes  = (rem_q >= 16'd8) ? 16'd8 : rem_q;
   assign beat_accept = sending && m_axis_tready;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      lane_d  = lane_q;
      word_d  = word_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_bcnt_empty) state_d = BCNT_RD;
         end
         BCNT_RD: begin
            state_d = BCNT_LAT;
         end
         BCNT_LAT: begin
            rem_d   = bcnt;
            // Oversize packets are flagged but still forwarded.
            state_d = (bcnt == 16'd0) ? DONE : PKT_RD;
         end
         PKT_RD: begin
            if (!fifo_pkt_empty) state_d = PKT_LAT;
         end
         PKT_LAT: begin
            word_d  = fifo_pkt_q;
            lane_d  = 2'd0;
            state_d = SEND;
         end
         SEND: begin
            if (m_axis_tready) begin
               // beat_bytes never exceeds rem_q, so this saturates at zero.
               rem_d  = rem_q - beat_bytes;
               lane_d = lane_q + 2'd1;
               if (beat_last) begin
                  state_d = DONE;
               end else if (lane_q == 2'd3) begin
                  state_d = PKT_RD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= 16'd0;
         lane_q  <= 2'd0;
         word_q  <= 256'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
      end
   end

   assign fifo_bcnt_rden = (state_q == BCNT_RD);
   assign fifo_pkt_rden  = (state_q == PKT_RD) && !fifo_pkt_empty;

   assign err_zero_len = (state_q == BCNT_LAT) && (bcnt == 16'd0);
   assign err_oversize = (state_q == BCNT_LAT) && (32'(bcnt) > MAX_PKT_BYTES);

   assign busy          = (state_q != IDLE);
   assign m_axis_tvalid = sending;
   assign m_axis_tdest  = TDEST_VAL;
   assign m_axis_tlast  = sending && beat_last;
   assign m_axis_tdata  = sending ? word_q[{lane_q, 6'd0} +: 64] : 64'd0;

   always_comb begin
      m_axis_tkeep = 8'h00;
      if (sending) begin
         m_axis_tkeep = (rem_q >= 16'd8) ? 8'hFF : ((8'd1 << rem_q[2:0]) - 8'd1);
      end
   end

`ifdef NETE_RX_UNPACK_STATS_EN
   logic [31:0] pkt_count_q;
   logic [31:0] byte_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count_q  <= 32'd0;
         byte_count_q <= 32'd0;
      end else if (beat_accept) begin
         // beat_bytes equals popcount(tkeep) for the current beat.
         byte_count_q <= byte_count_q + 32'(beat_bytes);
         if (beat_last) pkt_count_q <= pkt_count_q + 32'd1;
      end
   end

   assign pkt_count  = pkt_count_q;
   assign byte_count = byte_count_q;
`else
   logic unused_beat_accept;
   assign unused_beat_accept = beat_accept;
   assign pkt_count  = 32'd0;
   assign byte_count = 32'd0;
`endif

endmodule

// File: tb/tb_nete_rx_unpack.sv
// Bench for nete_rx_unpack: FIFO models, scoreboard of expected beats, per-packet
// counter checks (rden pulses, error pulses, first-beat latency).
module tb_nete_rx_unpack;

   localparam int unsigned MAX_BYTES = 2048;
   localparam logic [3:0]  DEST      = 4'hA;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [255:0] fifo_pkt_q;
   logic         fifo_pkt_empty;
   logic         fifo_pkt_rden;
   logic [63:0]  fifo_bcnt_q;
   logic         fifo_bcnt_empty;
   logic         fifo_bcnt_rden;
   logic [63:0]  m_axis_tdata;
   logic [7:0]   m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic [3:0]   m_axis_tdest;
   logic         m_axis_tready;
   logic         err_zero_len;
   logic         err_oversize;
   logic         busy;
   logic [31:0]  pkt_count;
   logic [31:0]  byte_count;

   nete_rx_unpack #(
      .MAX_PKT_BYTES (MAX_BYTES),
      .TDEST_VAL     (DEST)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fifo_pkt_q      (fifo_pkt_q),
      .fifo_pkt_empty  (fifo_pkt_empty),
      .fifo_pkt_rden   (fifo_pkt_rden),
      .fifo_bcnt_q     (fifo_bcnt_q),
      .fifo_bcnt_empty (fifo_bcnt_empty),
      .fifo_bcnt_rden  (fifo_bcnt_rden),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tdest    (m_axis_tdest),
      .m_axis_tready   (m_axis_tready),
      .err_zero_len    (err_zero_len),
      .err_oversize    (err_oversize),
      .busy            (busy),
      .pkt_count       (pkt_count),
      .byte_count      (byte_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   logic [255:0] pq[$];
   logic [63:0]  bq[$];
   beat_t        exp_q[$];

   int tick_n, n_bcnt_rd, n_pkt_rd, n_zero, n_over, n_beats;
   int first_valid_tick, over_tick, bcnt_rd_tick;
   int stall_cnt, tready_mode;
   bit stall_arm, busy_s, hold_pending;
   logic [63:0] h_data;
   logic [7:0]  h_keep;
   logic        h_last;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic upd_flags();
      fifo_pkt_empty  = (pq.size() == 0) || (stall_cnt > 0);
      fifo_bcnt_empty = (bq.size() == 0);
   endtask

   // One clock: sample at the falling edge, then update FIFO models after the rising edge.
   task automatic tick();
      bit    rd_b, rd_p;
      beat_t e;
      @(negedge clk);
      rd_b = fifo_bcnt_rden;
      rd_p = fifo_pkt_rden;
      if (rd_b) begin
         n_bcnt_rd++;
         bcnt_rd_tick = tick_n;
         chk("bcnt_rden_while_empty", fifo_bcnt_empty, 1'b0);
      end
      if (rd_p) begin
         n_pkt_rd++;
         chk("pkt_rden_while_empty", fifo_pkt_empty, 1'b0);
      end
      if (err_zero_len) n_zero++;
      if (err_oversize) begin
         n_over++;
         over_tick = tick_n;
      end
      if (m_axis_tvalid && first_valid_tick < 0) first_valid_tick = tick_n;
      if (hold_pending) begin
         chk("hold_valid", m_axis_tvalid, 1'b1);
         chk("hold_data", m_axis_tdata, h_data);
         chk("hold_keep", m_axis_tkeep, h_keep);
         chk("hold_last", m_axis_tlast, h_last);
      end
      hold_pending = m_axis_tvalid && !m_axis_tready;
      h_data = m_axis_tdata;
      h_keep = m_axis_tkeep;
      h_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
         n_beats++;
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tkeep", m_axis_tkeep, e.k);
            chk("tlast", m_axis_tlast, e.l);
         end
      end
      busy_s = busy;
      @(posedge clk);
      #1;
      if (rd_b && bq.size() > 0) fifo_bcnt_q = bq.pop_front();
      if (rd_p && pq.size() > 0) begin
         fifo_pkt_q = pq.pop_front();
         if (stall_arm) begin
            stall_arm = 1'b0;
            stall_cnt = 10;
         end
      end else if (stall_cnt > 0) begin
         stall_cnt--;
      end
      if (tready_mode == 1) m_axis_tready = ~m_axis_tready;
      upd_flags();
      tick_n++;
   endtask

   // Queue one packet into the FIFO models and its expected beats into the scoreboard.
   task automatic setup_pkt(input int bcnt, input int nwords, input int mode, input bit stall);
      logic [255:0] w;
      beat_t        b;
      int           rem;
      tick_n = 0; n_bcnt_rd = 0; n_pkt_rd = 0; n_zero = 0; n_over = 0; n_beats = 0;
      first_valid_tick = -1; over_tick = -1; bcnt_rd_tick = -1;
      hold_pending = 1'b0;
      tready_mode = mode;
      m_axis_tready = 1'b1;
      stall_arm = stall;
      rem = bcnt;
      for (int i = 0; i < nwords; i++) begin
         for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
         pq.push_back(w);
         for (int ln = 0; ln < 4; ln++) begin
            if (rem > 0) begin
               b.d = w[64*ln +: 64];
               b.k = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
               b.l = (rem <= 8);
               exp_q.push_back(b);
               rem = (rem >= 8) ? rem - 8 : 0;
            end
         end
      end
      bq.push_back({48'hA5A5_5A5A_C3C3, 16'(bcnt)});
      upd_flags();
   endtask

   task automatic run_pkt(input string name, input int bcnt, input int nwords, input int mode,
                          input bit stall);
      bit done;
      setup_pkt(bcnt, nwords, mode, stall);
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         tick();
         if (n_bcnt_rd > 0 && !busy_s) done = 1'b1;
      end
      chk({name, "_timeout"}, done, 1'b1);
      chk({name, "_leftover_beats"}, exp_q.size(), 0);
      chk({name, "_beats"}, n_beats, (bcnt + 7) / 8);
      chk({name, "_bcnt_rden"}, n_bcnt_rd, 1);
      chk({name, "_pkt_rden"}, n_pkt_rd, (bcnt + 31) / 32);
      chk({name, "_zero_err"}, n_zero, (bcnt == 0) ? 1 : 0);
      chk({name, "_over_err"}, n_over, (bcnt > int'(MAX_BYTES)) ? 1 : 0);
      if (bcnt > 0) chk({name, "_latency"}, first_valid_tick, 5);
      else chk({name, "_no_valid"}, first_valid_tick, -1);
      if (bcnt > int'(MAX_BYTES)) chk({name, "_over_timing"}, over_tick - bcnt_rd_tick, 1);
      exp_q.delete();
      m_axis_tready = 1'b1;
      tready_mode = 0;
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_tvalid"}, m_axis_tvalid, 1'b0);
      chk({name, "_tdata"}, m_axis_tdata, 64'd0);
      chk({name, "_tkeep"}, m_axis_tkeep, 8'd0);
      chk({name, "_tlast"}, m_axis_tlast, 1'b0);
      chk({name, "_tdest"}, m_axis_tdest, DEST);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_rdens"}, {fifo_pkt_rden, fifo_bcnt_rden}, 2'b00);
      chk({name, "_errs"}, {err_zero_len, err_oversize}, 2'b00);
      chk({name, "_counts"}, {pkt_count, byte_count}, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      m_axis_tready = 1'b1;
      fifo_pkt_q = '0;
      fifo_bcnt_q = '0;
      stall_cnt = 0;
      tready_mode = 0;
      upd_flags();
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      reset = 1'b0;

      run_pkt("b70", 70, 3, 0, 1'b0);
`ifdef NETE_RX_UNPACK_STATS_EN
      chk("stats_b70", {pkt_count, byte_count}, {32'd1, 32'd70});
`else
      chk("stats_b70", {pkt_count, byte_count}, 64'd0);
`endif
      run_pkt("b32_toggle", 32, 1, 1, 1'b0);
      run_pkt("b0", 0, 0, 0, 1'b0);
      run_pkt("b5000", 5000, 157, 0, 1'b0);
      run_pkt("b40_stall", 40, 2, 0, 1'b1);

      // Reset in the middle of a 64-byte packet, during its second beat.
      setup_pkt(64, 2, 0, 1'b0);
      for (int i = 0; i < 200 && n_beats < 1; i++) tick();
      chk("mid_reset_reached_beat1", n_beats, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      pq.delete();
      bq.delete();
      upd_flags();
      chk_idle_outputs("mid_reset");

      run_pkt("b8_after_reset", 8, 1, 0, 1'b0);
`ifdef NETE_RX_UNPACK_STATS_EN
      chk("stats_after_reset", {pkt_count, byte_count}, {32'd1, 32'd8});
`else
      chk("stats_after_reset", {pkt_count, byte_count}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
